// File: rtl/sign_restore_align.sv
// Sign FIFO + restoration stage for the sign-symmetric sigmoid/tanh path.
// Pairs each |x|-domain result with its queued sign flag, in order.
module sign_restore_align #(
  parameter int yDW   = 16,
  parameter int FRAC  = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic           sign_valid,
  input  logic           sign_ge,
  input  logic           y_valid,
  input  logic [yDW-1:0] y_in,
  output logic           out_valid,
  output logic [yDW-1:0] y_out,
  output logic [AW:0]    fifo_count,
  output logic           err_overflow,
  output logic           err_underflow
);

  localparam logic [yDW-1:0] ONE  = yDW'(1) << FRAC;
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;

  logic           w_en;
  logic           w_empty;
  logic           w_full;
  logic           w_push_req;
  logic           w_pop_req;
  logic           w_bypass;
  logic           w_push;
  logic           w_pop;
  logic           w_fire;
  logic           w_ovf;
  logic           w_unf;
  logic           w_sign;
  logic [yDW-1:0] w_ys;
  logic [yDW-1:0] w_res;
  logic [AW:0]    w_inc;
  logic [AW:0]    w_dec;

  assign w_en       = en & rst_n;
  assign w_empty    = (fifo_count == '0);
  assign w_full     = (fifo_count == FULL);
  assign w_push_req = w_en & sign_valid;
  assign w_pop_req  = w_en & y_valid;

  // Empty FIFO with both strobes: the flag goes straight to the result.
  assign w_bypass = w_push_req & w_pop_req & w_empty;
  assign w_pop    = w_pop_req & ~w_empty;
  assign w_push   = w_push_req & ~w_bypass & (~w_full | w_pop);
  assign w_fire   = w_pop | w_bypass;
  assign w_ovf    = w_push_req & w_full & ~w_pop;
  assign w_unf    = w_pop_req & w_empty & ~w_push_req;

  assign w_inc = {{AW{1'b0}}, w_push};
  assign w_dec = {{AW{1'b0}}, w_pop};

  assign w_sign = w_bypass ? sign_ge : r_mem[r_rptr];
  assign w_ys   = (y_in > ONE) ? ONE : y_in;

  always_comb begin
    w_res = w_ys;
    if (!w_sign) begin
      if (mode) w_res = -w_ys;
      else      w_res = ONE - w_ys;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      fifo_count    <= '0;
      out_valid     <= 1'b0;
      y_out         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (!en) begin
      out_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= sign_ge;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      fifo_count <= fifo_count + w_inc - w_dec;
      if (w_ovf) err_overflow  <= 1'b1;
      if (w_unf) err_underflow <= 1'b1;
      out_valid <= w_fire;
      if (w_fire) y_out <= w_res;
    end
  end

endmodule

// File: doc/sign_restore_align.md
Name: sign_restore_align

Overview:
- Back end of the sign-symmetric sigmoid/tanh path.
- The front-end sign comparator emits one x>=0 flag per sample. The activation core then evaluates only |x|, with multi-cycle latency.
- This block queues the sign flags in order, pairs each flag with the matching magnitude-domain result, and restores the full-range output:
  - sigmoid(-x) = ONE - sigmoid(|x|)
  - tanh(-x) = -tanh(|x|)

Parameters:
- yDW, 16, width of the activation result and of the restored output.
- FRAC, 12, fractional bits; ONE = 2^FRAC (4096).
- DEPTH, 8, sign FIFO entries; must be a power of 2.
- AW, 3, log2(DEPTH).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  block enable
- mode  input  1  0 = sigmoid, 1 = tanh; sampled when a result is paired
- sign_valid  input  1  sign flag strobe from the comparator
- sign_ge  input  1  1 = x >= 0, 0 = x < 0
- y_valid  input  1  magnitude result strobe from the activation core
- y_in  input  yDW  unsigned magnitude result, Q(yDW-FRAC).FRAC
- out_valid  output  1  restored result valid
- y_out  output  yDW  signed restored result
- fifo_count  output  AW+1  occupied sign entries
- err_overflow  output  1  sticky: sign flag dropped because FIFO was full
- err_underflow  output  1  sticky: result arrived with no sign available

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. All state updates on posedge clk.
- Reset (rst_n=0 at a clock edge): read/write pointers=0, fifo_count=0, out_valid=0, y_out=0, err_overflow=0, err_underflow=0. Reset mid-stream discards all queued flags; the next cycle is an empty FIFO.
- Effective enable EN = en & rst_n. When EN=0: no push, no pop, out_valid<=0, y_out<=0, FIFO contents and error flags held.
- Push: sign_valid=1 and EN=1 writes sign_ge at the write pointer and increments it. Pointers wrap modulo DEPTH.
- Pop: y_valid=1 and EN=1 with a sign available reads the oldest flag and increments the read pointer.
- Pairing is strictly FIFO order; the Nth result pairs with the Nth sign.
- Simultaneous push and pop:
  - Count unchanged.
  - When the FIFO is full, the push is accepted because the pop frees the slot; no overflow.
  - When the FIFO is empty, the incoming sign_ge bypasses to the pop (same-cycle pairing); no underflow.
- Push with FIFO full and no pop: the flag is dropped, err_overflow<=1, count stays DEPTH.
- Pop request with FIFO empty and no push: no output produced (out_valid<=0), err_underflow<=1.
- Error flags clear only on reset.
- Arithmetic, registered with 1-cycle latency from y_valid to out_valid:
  - ys = min(y_in, ONE); saturate out-of-range core results.
  - sign=1: y_out = ys, for either mode.
  - sign=0, mode=0: y_out = ONE - ys, range 0..ONE.
  - sign=0, mode=1: y_out = -ys, two's complement, range -ONE..0.
- out_valid=1 exactly one cycle per successful pop; otherwise 0.
- y_out holds its last value while out_valid=0 and EN=1.
- fifo_count reflects the registered state after each edge, range 0..DEPTH.

Test Plan:
1. Reset then push signs 1,0 (two cycles); then y_valid with y_in=3000 and 1000, mode=0 -> out_valid on the two following cycles with y_out=3000, then 3096; fifo_count 2 -> 0.
2. Same ordering with mode=1, signs 0,1, y_in=2048,4096 -> y_out=-2048 (0xF800), then 4096.
3. Push 9 signs with no pops, DEPTH=8 -> fifo_count=8, err_overflow=1 after the 9th; next 8 pops return the first 8 flags in order.
4. Empty FIFO: y_valid alone -> out_valid=0, err_underflow=1. Then sign_valid=1, sign_ge=0, y_valid=1, y_in=500, mode=0 in the same cycle -> bypass, y_out=3596, fifo_count stays 0.
5. Saturation: sign 0, mode=0, y_in=5000 -> y_out=0. Sign 0, mode=1, y_in=5000 -> y_out=-4096.
6. Push 3 signs, drive rst_n=0 for one cycle, then y_valid -> err_underflow=1, no output. Separately, with en=0 and sign_valid/y_valid asserted -> fifo_count and flags unchanged, out_valid=0.
